// File: rtl/acx_slave_reg_sta_pkg.sv
// Shared types and address helpers for the strided status-register bank.
package acx_slave_reg_sta_pkg;

  // Widest channel index the bank supports (NUM_CHAN up to 64).
  localparam int unsigned MAX_IDX_W = 6;

  typedef struct packed {
    logic                 rd;
    logic [MAX_IDX_W-1:0] idx;
  } dec_stage_t;

  function automatic int unsigned chan_idx_w(input int unsigned num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  function automatic logic [63:0] chan_addr(input logic [63:0]   base,
                                            input int unsigned   stride,
                                            input int unsigned   n);
    return base + 64'(n) * 64'(stride);
  endfunction

endpackage

// File: rtl/acx_slave_reg_sta_chan.sv
// One status register: live bits follow the input, sticky bits accumulate and
// clear on read, with a same-cycle set taking priority over the clear.
module acx_slave_reg_sta_chan #(
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]      INIT_VAL    = '0,
  parameter logic [DATA_WIDTH-1:0]      STICKY_MASK = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_sta,
  output logic [DATA_WIDTH-1:0] o_reg
);

  logic [DATA_WIDTH-1:0] reg_q, reg_d;

  // Fresh input always lands; only sticky bits remember, and not while being read.
  always_comb begin
    reg_d = i_sta | (STICKY_MASK & reg_q & {DATA_WIDTH{~i_clr}});
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      reg_q <= INIT_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign o_reg = reg_q;

endmodule

// File: rtl/acx_slave_reg_sta_bank.sv
// Bank of read-only status registers with a two-stage registered read path.
// Optional sticky-bit interrupt enabled by defining ACX_SLAVE_REG_STA_IRQ_EN.
module acx_slave_reg_sta_bank
  import acx_slave_reg_sta_pkg::*;
#(
  parameter int unsigned                   TGT_ADDR_WIDTH = 28,
  parameter int unsigned                   TGT_DATA_WIDTH = 32,
  parameter int unsigned                   NUM_CHAN       = 4,
  parameter logic [TGT_ADDR_WIDTH-1:0]     BASE_ADDR      = '0,
  parameter int unsigned                   ADDR_STRIDE    = 4,
  parameter logic [TGT_DATA_WIDTH-1:0]     INIT           = 'hDEADBEEF,
  parameter logic [TGT_DATA_WIDTH-1:0]     STICKY_MASK    = 'h0000FFFF
) (
  input  logic                               i_clk,
  input  logic                               i_rstn,
  input  logic                               i_rd,
  input  logic [TGT_ADDR_WIDTH-1:0]          i_addr,
  input  logic [NUM_CHAN*TGT_DATA_WIDTH-1:0] i_sta,
  output logic                               o_addr_hit,
  output logic [TGT_DATA_WIDTH-1:0]          o_read_data,
  output logic [NUM_CHAN*TGT_DATA_WIDTH-1:0] o_sta,
  output logic                               o_irq
);

  localparam int unsigned CHAN_IDX_W = chan_idx_w(NUM_CHAN);

  logic [TGT_DATA_WIDTH-1:0] sta_reg [NUM_CHAN];

  dec_stage_t                dec_d, dec_q;
  logic                      hit;
  logic [CHAN_IDX_W-1:0]     hit_idx;
  logic [TGT_DATA_WIDTH-1:0] rd_mux;
  logic                      addr_hit_q;
  logic [TGT_DATA_WIDTH-1:0] read_data_q;

  // Case equality keeps X/Z addresses from ever decoding as a hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned n = 0; n < NUM_CHAN; n++) begin
      if (i_addr === TGT_ADDR_WIDTH'(chan_addr(64'(BASE_ADDR), ADDR_STRIDE, n))) begin
        hit     = 1'b1;
        hit_idx = CHAN_IDX_W'(n);
      end
    end
    dec_d.rd  = i_rd & hit;
    dec_d.idx = MAX_IDX_W'(hit_idx);
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned n = 0; n < NUM_CHAN; n++) begin
      if (dec_q.idx == MAX_IDX_W'(n)) begin
        rd_mux = sta_reg[n];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      dec_q       <= '0;
      addr_hit_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      dec_q      <= dec_d;
      addr_hit_q <= dec_q.rd;
      if (dec_q.rd) begin
        read_data_q <= rd_mux;
      end
    end
  end

  assign o_addr_hit  = addr_hit_q;
  assign o_read_data = read_data_q;

  for (genvar n = 0; n < NUM_CHAN; n++) begin : g_chan
    logic clr;
    // Clear coincides with the capture into o_read_data, so the pre-clear value is returned.
    assign clr = dec_q.rd && (dec_q.idx == MAX_IDX_W'(n));

    acx_slave_reg_sta_chan #(
      .DATA_WIDTH  (TGT_DATA_WIDTH),
      .INIT_VAL    (TGT_DATA_WIDTH'(chan_addr(64'(BASE_ADDR), ADDR_STRIDE, n)) + INIT),
      .STICKY_MASK (STICKY_MASK)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_clr  (clr),
      .i_sta  (i_sta[n*TGT_DATA_WIDTH +: TGT_DATA_WIDTH]),
      .o_reg  (sta_reg[n])
    );

    assign o_sta[n*TGT_DATA_WIDTH +: TGT_DATA_WIDTH] = sta_reg[n];
  end

`ifdef ACX_SLAVE_REG_STA_IRQ_EN
  logic irq_d, irq_q;

  always_comb begin
    irq_d = 1'b0;
    for (int unsigned n = 0; n < NUM_CHAN; n++) begin
      irq_d = irq_d | (|(sta_reg[n] & STICKY_MASK));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

endmodule
